// File: rtl/fir_channel_arbiter_pkg.sv
// fir_pkg: shared constants and FSM state type for the FIR channel arbiter.
package fir_pkg;

  localparam int SAMPLE_W        = 8;
  localparam int DEF_WDOG_CYCLES = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN
  } state_t;

endpackage

// File: rtl/fir_channel_arbiter_rr_grant.sv
// rr_grant: combinational round-robin picker; scans ptr+1, ptr+2, ... with wrap
// and returns a one-hot grant plus the encoded index of the winner.
module rr_grant #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N-1:0]     o_grant,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_any
);

  always_comb begin
    logic [IDX_W-1:0] w_cand;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N; k++) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_cand]) begin
        o_grant[w_cand] = 1'b1;
        o_idx           = w_cand;
        o_any           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_channel_arbiter.sv
// fir_channel_arbiter: round-robin scheduler time-sharing one FIR MAC engine among NUM_CH channels.
// Optional engine-timeout watchdog is enabled by defining FIR_ARB_WATCHDOG_EN.
module fir_channel_arbiter
  import fir_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int WDOG_CYCLES = DEF_WDOG_CYCLES
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_CH-1:0]          i_ch_valid,
  input  logic [NUM_CH*SAMPLE_W-1:0] i_ch_data,
  output logic [NUM_CH-1:0]          o_ch_ready,
  output logic                       o_eng_start,
  output logic [SAMPLE_W-1:0]        o_eng_sample,
  output logic [CH_W-1:0]            o_eng_ch,
  input  logic                       i_eng_done,
  input  logic [SAMPLE_W-1:0]        i_eng_result,
  output logic                       o_out_valid,
  output logic [SAMPLE_W-1:0]        o_out_data,
  output logic [CH_W-1:0]            o_out_ch,
  input  logic                       i_out_ready,
  output logic                       o_err
);

  state_t                r_state;
  logic [CH_W-1:0]       r_ptr;
  logic                  r_eng_start;
  logic [SAMPLE_W-1:0]   r_eng_sample;
  logic [CH_W-1:0]       r_eng_ch;
  logic                  r_out_valid;
  logic [SAMPLE_W-1:0]   r_out_data;
  logic [CH_W-1:0]       r_out_ch;

  logic [NUM_CH-1:0]     w_grant;
  logic [CH_W-1:0]       w_idx;
  logic                  w_any;
  logic [SAMPLE_W-1:0]   w_sample;

`ifdef FIR_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES) + 1;
  logic [WD_W-1:0]       r_wdog;
  logic                  r_err;
  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

  rr_grant #(
    .N    (NUM_CH),
    .IDX_W(CH_W)
  ) u_rr_grant (
    .i_req  (i_ch_valid),
    .i_ptr  (r_ptr),
    .o_grant(w_grant),
    .o_idx  (w_idx),
    .o_any  (w_any)
  );

  // Ready is only offered in IDLE, and is forced low while reset is held.
  assign o_ch_ready = (r_state == IDLE && i_rst_n) ? w_grant : '0;

  always_comb begin
    w_sample = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_idx == CH_W'(k)) begin
        w_sample = i_ch_data[k*SAMPLE_W +: SAMPLE_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= IDLE;
      r_ptr        <= CH_W'(NUM_CH - 1);
      r_eng_start  <= 1'b0;
      r_eng_sample <= '0;
      r_eng_ch     <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_ch     <= '0;
`ifdef FIR_ARB_WATCHDOG_EN
      r_wdog       <= '0;
      r_err        <= 1'b0;
`endif
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_any) begin
            r_eng_sample <= w_sample;
            r_eng_ch     <= w_idx;
            r_ptr        <= w_idx;
            r_eng_start  <= 1'b1;
            r_state      <= ISSUE;
          end
        end
        ISSUE: begin
          r_eng_start <= 1'b0;
          r_state     <= WAIT;
`ifdef FIR_ARB_WATCHDOG_EN
          r_wdog      <= '0;
`endif
        end
        WAIT: begin
          if (i_eng_done) begin
            r_out_data  <= i_eng_result;
            r_out_ch    <= r_eng_ch;
            r_out_valid <= 1'b1;
            r_state     <= DRAIN;
          end
`ifdef FIR_ARB_WATCHDOG_EN
          // A stuck engine abandons the sample; ptr already points past it.
          else if (r_wdog == WD_W'(WDOG_CYCLES - 1)) begin
            r_err   <= 1'b1;
            r_state <= IDLE;
          end else begin
            r_wdog <= r_wdog + 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_eng_start  = r_eng_start;
  assign o_eng_sample = r_eng_sample;
  assign o_eng_ch     = r_eng_ch;
  assign o_out_valid  = r_out_valid;
  assign o_out_data   = r_out_data;
  assign o_out_ch     = r_out_ch;

endmodule

// File: tb/tb_fir_channel_arbiter.sv
// tb_fir_channel_arbiter: randomized and directed bench with a transaction-level reference
// model and a simple latency-programmable engine model. Watchdog checks need FIR_ARB_WATCHDOG_EN.
module tb_fir_channel_arbiter;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;
  localparam int WDOG   = 16;

  logic        clk;
  logic        rstN;
  logic [3:0]  chValid;
  logic [31:0] chData;
  logic [3:0]  chReady;
  logic        engStart;
  logic [7:0]  engSample;
  logic [1:0]  engCh;
  logic        engDone;
  logic [7:0]  engResult;
  logic        outValid;
  logic [7:0]  outData;
  logic [1:0]  outCh;
  logic        outReady;
  logic        err;

  fir_channel_arbiter #(
    .NUM_CH     (NUM_CH),
    .CH_W       (CH_W),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rstN),
    .i_ch_valid  (chValid),
    .i_ch_data   (chData),
    .o_ch_ready  (chReady),
    .o_eng_start (engStart),
    .o_eng_sample(engSample),
    .o_eng_ch    (engCh),
    .i_eng_done  (engDone),
    .i_eng_result(engResult),
    .o_out_valid (outValid),
    .o_out_data  (outData),
    .o_out_ch    (outCh),
    .i_out_ready (outReady),
    .o_err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checkCount = 0;
  int passCount  = 0;
  int cycleNo    = 0;

  // Reference model: one outstanding transaction, tracked by its life events.
  bit         mBusy, mStartDue, mWaiting, mDraining, mErr;
  int         mLastGrant, mCh, mExpCh, mWdog;
  logic [7:0] mSample, mData;

  // Engine model.
  int         engCnt, engLat;
  bit         engHang, engFixedEn, injectDone;
  logic [7:0] engFixedVal;

  // Observations of the DUT since the last clearObs.
  int         obsGrants, obsHs, overlapCount, obsStarts, obsReadyCycles, obsOutValidCycles;
  int         xferCycle, firstOutCycle, errRiseCycle;
  logic [7:0] firstOutData, startSample, lastOutData;
  logic [1:0] firstOutCh, startCh, lastOutCh;
  logic [3:0] lastReady;
  logic       lastErr, lastOutValid, prevOutValid, prevErr;
  int         dutGrantLog[$];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  function automatic int pick(input logic [3:0] v, input int last);
    int c;
    for (int k = 1; k <= NUM_CH; k++) begin
      c = (last + k) % NUM_CH;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [7:0] engFn(input logic [7:0] s, input int ch);
    return (s ^ 8'h5a) + 8'(ch * 3 + 1);
  endfunction

  task automatic resetModel();
    mBusy = 0; mStartDue = 0; mWaiting = 0; mDraining = 0; mErr = 0;
    mLastGrant = NUM_CH - 1; mCh = 0; mExpCh = 0; mWdog = 0;
    mSample = '0; mData = '0;
  endtask

  task automatic clearObs();
    obsGrants = 0; obsHs = 0; overlapCount = 0; obsStarts = 0;
    obsReadyCycles = 0; obsOutValidCycles = 0;
    xferCycle = -1; firstOutCycle = -1; errRiseCycle = -1;
    firstOutData = '0; firstOutCh = '0; startSample = '0; startCh = '0;
    dutGrantLog.delete();
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data, input logic ready);
    chValid  = valid;
    chData   = data;
    outReady = ready;
  endtask

  // One clock: check at the negedge against the model, advance model and engine, drive at posedge+1.
  task automatic stepCycle();
    int         g;
    logic [3:0] expReady;
    bit         doneNext;
    logic [7:0] resNext;
    @(negedge clk);
    cycleNo++;
    lastReady = chReady; lastErr = err; lastOutValid = outValid;
    lastOutData = outData; lastOutCh = outCh;
    doneNext = 0;
    if (!rstN) begin
      checkOutput("rstReady", chReady, 4'b0);
      checkOutput("rstStart", engStart, 1'b0);
      checkOutput("rstSample", engSample, 8'h0);
      checkOutput("rstEngCh", engCh, 2'd0);
      checkOutput("rstOutValid", outValid, 1'b0);
      checkOutput("rstOutData", outData, 8'h0);
      checkOutput("rstOutCh", outCh, 2'd0);
      checkOutput("rstErr", err, 1'b0);
      resetModel();
      engCnt = 0;
      prevOutValid = 0; prevErr = 0;
    end else begin
      g = mBusy ? -1 : pick(chValid, mLastGrant);
      expReady = (g >= 0) ? 4'(1 << g) : 4'b0;
      checkOutput("chReady", chReady, expReady);
      checkOutput("engStart", engStart, mStartDue);
      checkOutput("outValid", outValid, mDraining);
      checkOutput("err", err, mErr);
      if (mStartDue || mWaiting) begin
        checkOutput("engSample", engSample, mSample);
        checkOutput("engCh", engCh, mCh);
      end
      if (mDraining) begin
        checkOutput("outData", outData, mData);
        checkOutput("outCh", outCh, mExpCh);
      end
      if ((chReady & chValid) != 4'b0) begin
        if (obsGrants != obsHs) overlapCount++;
        obsGrants++;
        xferCycle = cycleNo;
        dutGrantLog.push_back(pick(chReady, NUM_CH - 1));
      end
      if (outValid && outReady) obsHs++;
      if (chReady != 4'b0) obsReadyCycles++;
      if (outValid) obsOutValidCycles++;
      if (engStart) begin
        if (obsStarts == 0) begin startSample = engSample; startCh = engCh; end
        obsStarts++;
      end
      if (outValid && !prevOutValid && firstOutCycle < 0) begin
        firstOutCycle = cycleNo; firstOutData = outData; firstOutCh = outCh;
      end
      if (err && !prevErr && errRiseCycle < 0) errRiseCycle = cycleNo;
      prevOutValid = outValid; prevErr = err;

      if (g >= 0) begin
        mLastGrant = g; mCh = g; mSample = chData[g*8 +: 8];
        mBusy = 1; mStartDue = 1;
      end else if (mStartDue) begin
        mStartDue = 0; mWaiting = 1; mWdog = 0;
      end else if (mWaiting) begin
        if (engDone) begin
          mWaiting = 0; mDraining = 1; mExpCh = mCh;
          mData = engFixedEn ? engFixedVal : engFn(mSample, mCh);
        end
`ifdef FIR_ARB_WATCHDOG_EN
        else if (mWdog == WDOG - 1) begin
          mErr = 1; mWaiting = 0; mBusy = 0;
        end else mWdog++;
`endif
      end else if (mDraining && outReady) begin
        mDraining = 0; mBusy = 0;
      end

      if (engStart) engCnt = engLat;
      else if (engCnt > 0) begin
        engCnt--;
        if (engCnt == 0 && !engHang) doneNext = 1;
      end
    end
    resNext = engFixedEn ? engFixedVal : engFn(engSample, int'(engCh));
    if (injectDone) begin doneNext = 1; injectDone = 0; end
    @(posedge clk);
    #1;
    engDone   = doneNext;
    engResult = resNext;
  endtask

  task automatic resetPulse();
    rstN = 1'b0;
    repeat (2) stepCycle();
    rstN = 1'b1;
  endtask

  task automatic waitGrant(input string tag);
    int start = obsGrants;
    for (int n = 0; n < 20 && obsGrants == start; n++) stepCycle();
    if (obsGrants == start) checkOutput(tag, 0, 1);
  endtask

  task automatic waitIdle(input string tag);
    for (int n = 0; n < 100 && mBusy; n++) stepCycle();
    if (mBusy) checkOutput(tag, 0, 1);
  endtask

  int         rrExp[5] = '{0, 1, 2, 3, 0};
  logic [7:0] bpSample;
  int         hsBefore, wdXfer;

  initial begin
    engLat = 3; engHang = 0; engFixedEn = 0; engFixedVal = '0; injectDone = 0; engCnt = 0;
    engDone = 0; engResult = '0; prevOutValid = 0; prevErr = 0;
    applyStimulus(4'b0, 32'h0, 1'b1);
    rstN = 1'b0;
    resetModel();
    clearObs();
    repeat (3) stepCycle();
    rstN = 1'b1;

    // Idle after reset with nothing requesting.
    repeat (5) stepCycle();
    checkOutput("idleNoStart", obsStarts, 0);
    checkOutput("idleNoReady", obsReadyCycles, 0);

    // Single channel: ch2 sends -5, engine answers 7.
    clearObs();
    engFixedEn = 1; engFixedVal = 8'd7; engLat = 3;
    applyStimulus(4'b0100, 32'h00FB_0000, 1'b1);
    waitGrant("singleGrantTimeout");
    chValid = 4'b0;
    waitIdle("singleDoneTimeout");
    repeat (2) stepCycle();
    checkOutput("singleReadyCycles", obsReadyCycles, 1);
    checkOutput("singleGrantCh", dutGrantLog.size() > 0 ? dutGrantLog[0] : -1, 2);
    checkOutput("singleEngSample", startSample, 8'hFB);
    checkOutput("singleEngCh", startCh, 2'd2);
    checkOutput("singleLatency", firstOutCycle - xferCycle, 6);
    checkOutput("singleOutData", firstOutData, 8'd7);
    checkOutput("singleOutCh", firstOutCh, 2'd2);
    engFixedEn = 0;

    // Round robin with every channel requesting.
    resetPulse();
    clearObs();
    chValid = 4'hF; outReady = 1'b1;
    for (int i = 0; i < 200 && dutGrantLog.size() < 5; i++) begin
      chData = $urandom; engLat = $urandom_range(1, 4);
      stepCycle();
    end
    checkOutput("rrGrantCount", dutGrantLog.size() >= 5, 1);
    for (int i = 0; i < 5 && i < dutGrantLog.size(); i++)
      checkOutput($sformatf("rrGrant%0d", i), dutGrantLog[i], rrExp[i]);
    checkOutput("rrOverlap", overlapCount, 0);
    chValid = 4'b0;
    waitIdle("rrDrainTimeout");

    // Backpressure: out_ready low for 10 cycles while a result waits.
    clearObs();
    bpSample = 8'($urandom);
    applyStimulus(4'b1000, {bpSample, 24'($urandom)}, 1'b0);
    engLat = 2;
    waitGrant("bpGrantTimeout");
    chValid = 4'hF;
    for (int n = 0; n < 30 && firstOutCycle < 0; n++) stepCycle();
    checkOutput("bpOutSeen", firstOutCycle >= 0, 1);
    for (int n = 0; n < 10; n++) begin
      stepCycle();
      checkOutput("bpHoldValid", lastOutValid, 1'b1);
      checkOutput("bpHoldData", lastOutData, engFn(bpSample, 3));
      checkOutput("bpHoldCh", lastOutCh, 2'd3);
      checkOutput("bpReadyZero", lastReady, 4'b0);
    end
    hsBefore = obsHs;
    chValid = 4'b0; outReady = 1'b1;
    repeat (4) stepCycle();
    checkOutput("bpHandshakes", obsHs - hsBefore, 1);

    // Reset while the engine is busy; a late done must be ignored.
    clearObs();
    engLat = 5;
    applyStimulus(4'b0010, $urandom, 1'b1);
    waitGrant("rstGrantTimeout");
    chValid = 4'b0;
    repeat (2) stepCycle();
    checkOutput("rstInWait", mWaiting, 1'b1);
    resetPulse();
    injectDone = 1;
    repeat (8) stepCycle();
    checkOutput("rstNoOut", obsOutValidCycles, 0);
    chValid = 4'hF;
    stepCycle();
    checkOutput("rstNextGrant", lastReady, 4'b0001);
    chValid = 4'b0;
    waitIdle("rstDrainTimeout");

`ifdef FIR_ARB_WATCHDOG_EN
    // Engine never answers: err after WDOG cycles in WAIT, then the next channel.
    resetPulse();
    clearObs();
    engHang = 1;
    applyStimulus(4'b0001, $urandom, 1'b1);
    waitGrant("wdGrantTimeout");
    wdXfer = xferCycle;
    chValid = 4'b0;
    for (int n = 0; n < 40 && errRiseCycle < 0; n++) stepCycle();
    checkOutput("wdogRise", errRiseCycle - (wdXfer + 2), WDOG);
    repeat (3) stepCycle();
    checkOutput("wdogSticky", lastErr, 1'b1);
    checkOutput("wdogNoOut", obsOutValidCycles, 0);
    chValid = 4'hF;
    stepCycle();
    checkOutput("wdogNextGrant", lastReady, 4'b0010);
    chValid = 4'b0;
    engHang = 0;
    waitIdle("wdogDrainTimeout");
`endif

    // Randomized traffic against the model.
    resetPulse();
    clearObs();
    for (int n = 0; n < 600; n++) begin
      applyStimulus(4'($urandom), $urandom, $urandom_range(0, 3) != 0);
      engLat = $urandom_range(1, 5);
      stepCycle();
    end
    applyStimulus(4'b0, 32'h0, 1'b1);
    waitIdle("randDrainTimeout");
    checkOutput("randOverlap", overlapCount, 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
